// File: rtl/menu_pkg.sv
// Shared definitions for the title/menu overlay.
//   - menu_state_e : overlay state machine encoding
//   - vga_bus_t    : VGA pipeline bus (hcount, vcount, syncs, blanks, rgb)
//   - VGA_BUS_SIZE : flat width of vga_bus_t for port declarations
//   - FONT_W/FONT_H: glyph geometry of the shared 8x16 font ROM
//   - idx_width()  : index width helper, never narrower than one bit
package menu_pkg;

  localparam int FONT_W = 8;
  localparam int FONT_H = 16;

  localparam logic [11:0] TEXT_RGB_DEF   = 12'hFFF;
  localparam logic [11:0] HILITE_RGB_DEF = 12'hF00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MENU    = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_DONE    = 2'd3
  } menu_state_e;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  localparam int VGA_BUS_SIZE = $bits(vga_bus_t);

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/menu_text_rom.sv
// Combinational menu text table.
//   row       : menu row index
//   col       : character column within the row
//   char_code : 7-bit ASCII code; space (0x20) for any out-of-range entry
module menu_text_rom
  import menu_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int ITEM_CHARS = 16
) (
  input  logic [3:0] row,
  input  logic [6:0] col,
  output logic [6:0] char_code
);

  localparam logic [127:0] ROW0  = "A: 1 PLAYER     ";
  localparam logic [127:0] ROW1  = "B: 2 PLAYERS    ";
  localparam logic [127:0] ROW2  = "C: OPTIONS      ";
  localparam logic [127:0] ROW3  = "D: QUIT         ";
  localparam logic [127:0] BLANK = "                ";

  logic [127:0] line_str;
  logic [3:0]   byte_idx;
  logic [7:0]   ch;

  always_comb begin
    line_str = BLANK;
    case (row)
      4'd0:    line_str = ROW0;
      4'd1:    line_str = ROW1;
      4'd2:    line_str = ROW2;
      4'd3:    line_str = ROW3;
      default: line_str = BLANK;
    endcase
    // Leftmost character of a string literal sits in the top byte.
    byte_idx  = 4'd15 - col[3:0];
    ch        = line_str[{byte_idx, 3'b000} +: 8];
    char_code = 7'h20;
    if ((int'(row) < N_ITEMS) && (int'(col) < ITEM_CHARS) && (col < 7'd16))
      char_code = ch[6:0];
  end

endmodule

// File: rtl/title_menu.sv
// Menu / title-screen overlay for the VGA pipeline.
//   pclk, rst          : pixel clock, synchronous active-high reset
//   vga_in / vga_out   : VGA bus in, bus out with menu text overlaid (2-cycle latency)
//   enable             : menu active
//   btn_up/down/sel    : single-cycle debounced button pulses
//   font_addr/font_data: {char_code, char_line} to the shared font ROM, glyph row back
//   sel_index/valid/ready : chosen item, valid/ready handshake
module title_menu
  import menu_pkg::*;
#(
  parameter int          N_ITEMS      = 4,
  parameter int          ITEM_CHARS   = 16,
  parameter int          X_POS        = 320,
  parameter int          Y_POS        = 240,
  parameter int          ROW_PITCH    = 32,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] TEXT_RGB     = TEXT_RGB_DEF,
  parameter logic [11:0] HILITE_RGB   = HILITE_RGB_DEF
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic [VGA_BUS_SIZE-1:0]       vga_in,
  output logic [VGA_BUS_SIZE-1:0]       vga_out,
  input  logic                          enable,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_sel,
  output logic [10:0]                   font_addr,
  input  logic [7:0]                    font_data,
  output logic [idx_width(N_ITEMS)-1:0] sel_index,
  output logic                          sel_valid,
  input  logic                          sel_ready
);

  localparam int IW  = idx_width(N_ITEMS);
  localparam int FW  = idx_width(BLINK_FRAMES);
  localparam int RSH = $clog2(ROW_PITCH);

  localparam logic [IW-1:0] LAST_ITEM  = IW'(N_ITEMS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);
  localparam logic [11:0]   X_LO       = 12'(X_POS);
  localparam logic [11:0]   X_HI       = 12'(X_POS + FONT_W * ITEM_CHARS);
  localparam logic [11:0]   Y_LO       = 12'(Y_POS);
  localparam logic [11:0]   Y_HI       = 12'(Y_POS + N_ITEMS * ROW_PITCH);
  localparam logic [11:0]   LINE_MASK  = 12'(ROW_PITCH - 1);

  vga_bus_t pix_in, s1_bus, out_bus;
  assign pix_in  = vga_in;
  assign vga_out = out_bus;

  menu_state_e   state;
  logic [IW-1:0] cursor, disp_cursor;
  logic [FW-1:0] frame_cnt;
  logic          phase, vblnk_d, vblnk_rise;

  assign vblnk_rise = pix_in.vblnk & ~vblnk_d;

  // Stage 0: box geometry from the incoming pixel
  logic [11:0] hx, vy, dx, dy, line_off;
  logic [3:0]  row;
  logic [6:0]  col, char_code;
  logic        box_hit, in_gap, on_cursor_row, overlay_on;

  always_comb begin
    hx            = {1'b0, pix_in.hcount};
    vy            = {1'b0, pix_in.vcount};
    dx            = hx - X_LO;
    dy            = vy - Y_LO;
    box_hit       = (hx >= X_LO) && (hx < X_HI) && (vy >= Y_LO) && (vy < Y_HI);
    line_off      = dy & LINE_MASK;
    in_gap        = line_off >= 12'(FONT_H);
    row           = 4'(dy >> RSH);
    col           = 7'(dx >> 3);
    on_cursor_row = (row == 4'(disp_cursor));
    overlay_on    = (state != ST_IDLE);
  end

  menu_text_rom #(
    .N_ITEMS   (N_ITEMS),
    .ITEM_CHARS(ITEM_CHARS)
  ) u_text_rom (
    .row      (row),
    .col      (col),
    .char_code(char_code)
  );

  // The font ROM registers this address on the same edge that loads stage 1,
  // so its glyph row lines up with the stage-1 registers for stage 2.
  assign font_addr = (overlay_on && box_hit && !in_gap) ? {char_code, line_off[3:0]} : '0;

  // Control: state, cursor, blink and selection handshake
  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cursor      <= '0;
      disp_cursor <= '0;
      frame_cnt   <= '0;
      phase       <= 1'b1;
      vblnk_d     <= 1'b0;
      sel_index   <= '0;
      sel_valid   <= 1'b0;
    end else begin
      vblnk_d <= pix_in.vblnk;
      if (vblnk_rise) begin
        disp_cursor <= cursor;
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_MENU;
        end
        ST_MENU: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (btn_sel) begin
            state     <= ST_CONFIRM;
            sel_index <= cursor;
            sel_valid <= 1'b1;
          end else if (btn_up && !btn_down) begin
            // a move restarts the blink visible, overriding a same-cycle frame tick
            cursor    <= (cursor == '0) ? LAST_ITEM : cursor - IW'(1);
            frame_cnt <= '0;
            phase     <= 1'b1;
          end else if (btn_down && !btn_up) begin
            cursor    <= (cursor == LAST_ITEM) ? '0 : cursor + IW'(1);
            frame_cnt <= '0;
            phase     <= 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (!enable) begin
            state     <= ST_IDLE;
            sel_valid <= 1'b0;
          end else if (sel_ready) begin
            state     <= ST_DONE;
            sel_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          if (!enable) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: register pixel and draw decision
  logic       s1_overlay, s1_draw, s1_hilite;
  logic [2:0] s1_bit;

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_bus     <= '0;
      s1_overlay <= 1'b0;
      s1_draw    <= 1'b0;
      s1_hilite  <= 1'b0;
      s1_bit     <= '0;
    end else begin
      s1_bus     <= pix_in;
      s1_overlay <= overlay_on;
      // cursor row during the dark blink half is left to the background
      s1_draw    <= overlay_on && box_hit && !in_gap && !(on_cursor_row && !phase);
      s1_hilite  <= on_cursor_row;
      s1_bit     <= dx[2:0];
    end
  end

  // Stage 2: colour selection
  always_ff @(posedge pclk) begin
    if (rst) begin
      out_bus <= '0;
    end else begin
      out_bus <= s1_bus;
      if (s1_overlay) begin
        if (s1_bus.hblnk || s1_bus.vblnk)
          out_bus.rgb <= '0;
        else if (s1_draw && font_data[3'd7 - s1_bit])
          out_bus.rgb <= s1_hilite ? HILITE_RGB : TEXT_RGB;
      end
    end
  end

endmodule
